fifo_wr_arbiter: RTL and testbench

//  Shares the single write port of one fifo instance between NUM_REQ producers.

---
 rtl/fifo_wr_arbiter_if.sv | 42 ++++
 rtl/fifo_wr_arbiter.sv | 100 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Producer and fifo write-port bundle for fifo_wr_arbiter.
// The slave side is the arbiter; the master side is the producers plus the fifo.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_wren;
    logic [DATA_W-1:0]         fifo_wdata;
    logic                      grant_valid;
    logic [IDW-1:0]            grant_id;

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        output fifo_full,
        input  req_ready,
        input  fifo_wren,
        input  fifo_wdata,
        input  grant_valid,
        input  grant_id
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  fifo_full,
        output req_ready,
        output fifo_wren,
        output fifo_wdata,
        output grant_valid,
        output grant_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ producers.
// A grant lasts at most BURST_MAX beats, and each release costs one idle cycle.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input logic              clk,
    input logic              rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(BURST_MAX + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [IDW-1:0] gid;
    logic [IDW-1:0] gid_d;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] rr_ptr_d;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] gid_inc;
    logic [CW-1:0]  beat_cnt;
    logic [CW-1:0]  beat_cnt_d;
    logic           gv;
    logic           xfer;
    logic           at_limit;
    logic           release_now;
    int             idx;

    assign gv          = (state == GRANT);
    assign xfer        = gv & bus.req_valid[gid] & ~bus.fifo_full;
    assign at_limit    = (beat_cnt == CW'(BURST_MAX - 1));
    assign release_now = ~bus.req_valid[gid]
                       | (xfer & (bus.req_last[gid] | at_limit));
    assign gid_inc     = (gid == IDW'(NUM_REQ - 1)) ? '0 : gid + IDW'(1);

    // Descending scan so the requester closest to rr_ptr is the last writer.
    always_comb begin
        pick = rr_ptr;
        idx  = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (bus.req_valid[idx]) pick = IDW'(idx);
        end
    end

    always_comb begin
        state_d    = state;
        gid_d      = gid;
        rr_ptr_d   = rr_ptr;
        beat_cnt_d = beat_cnt;
        unique case (state)
            IDLE: begin
                if (|bus.req_valid) begin
                    gid_d      = pick;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (xfer) beat_cnt_d = beat_cnt + CW'(1);
                if (release_now) begin
                    rr_ptr_d = gid_inc;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gid      <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_d;
            gid      <= gid_d;
            rr_ptr   <= rr_ptr_d;
            beat_cnt <= beat_cnt_d;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (gv) bus.req_ready[gid] = ~bus.fifo_full;
    end

    assign bus.fifo_wren   = xfer;
    assign bus.fifo_wdata  = gv ? bus.req_data[gid*DATA_W +: DATA_W] : '0;
    assign bus.grant_valid = gv;
    assign bus.grant_id    = gid;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, bursts, rotation,
// backpressure, last/limit interplay and valid drop.
module tb_fifo_wr_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .BURST_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.fifo_full = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_chk++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL rst_gv got %0b want 0", bus.grant_valid); end
        n_chk++; if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_gid got %0d want 0", bus.grant_id); end
        n_chk++; if (bus.fifo_wren !== 1'b0) begin n_fail++; $display("FAIL rst_wren got %0b want 0", bus.fifo_wren); end
        bus.req_valid = 4'b0010;
        bus.req_data[8 +: 8] = 8'h01;
        bus.req_last  = 4'b0010;
        step();
        step();
        bus.req_valid = 4'b0100;
        bus.req_last  = '0;
        bus.req_data[16 +: 8] = 8'hA1;
        step();
        #1;
        n_chk++; if (bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL rst_pre_gid got %0d want 2", bus.grant_id); end
        n_chk++; if (bus.fifo_wdata !== 8'hA1) begin n_fail++; $display("FAIL rst_pre_wdata got %h want a1", bus.fifo_wdata); end
        step();
        bus.req_data[16 +: 8] = 8'hA2;
        #1;
        rst = 1'b1;
        #1;
        n_chk++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_gv got %0b want 0", bus.grant_valid); end
        n_chk++; if (bus.fifo_wren !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wren got %0b want 0", bus.fifo_wren); end
        n_chk++; if (bus.fifo_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_mid_wdata got %h want 00", bus.fifo_wdata); end
        n_chk++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_ready got %b want 0000", bus.req_ready); end
        n_chk++; if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_mid_gid got %0d want 0", bus.grant_id); end
        bus.req_valid = 4'b1111;
        step();
        rst = 1'b0;
        #1;
        n_chk++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL rst_idle_gv got %0b want 0", bus.grant_valid); end
        step();
        #1;
        n_chk++; if (bus.grant_valid !== 1'b1) begin n_fail++; $display("FAIL rst_first_gv got %0b want 1", bus.grant_valid); end
        n_chk++; if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_first_gid got %0d want 0", bus.grant_id); end
    endtask

    task automatic test_single_producer();
        bit       ew[8] = '{0, 1, 1, 1, 1, 0, 1, 1};
        bit [7:0] ed[8] = '{8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00, 8'h15, 8'h16};
        int       b = 0;
        bit       acc;
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_data[8 +: 8] = 8'h11;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_chk++; if (bus.fifo_wren !== ew[c]) begin n_fail++; $display("FAIL single_wren c%0d got %0b want %0b", c, bus.fifo_wren, ew[c]); end
            if (ew[c]) begin
                n_chk++; if (bus.fifo_wdata !== ed[c]) begin n_fail++; $display("FAIL single_wdata c%0d got %h want %h", c, bus.fifo_wdata, ed[c]); end
                n_chk++; if (bus.grant_id !== 2'd1) begin n_fail++; $display("FAIL single_gid c%0d got %0d want 1", c, bus.grant_id); end
            end
            acc = bus.fifo_wren;
            step();
            if (acc) begin
                b++;
                if (b == 6) bus.req_valid = '0;
                else bus.req_data[8 +: 8] = 8'(8'h11 + b);
            end
        end
    endtask

    task automatic test_round_robin();
        int id;
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = 8'(8'h30 + i);
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c % 2 == 1) begin
                id = ((c - 1) / 2) % 4;
                n_chk++; if (bus.grant_id !== 2'(id)) begin n_fail++; $display("FAIL rr_gid c%0d got %0d want %0d", c, bus.grant_id, id); end
                n_chk++; if (bus.fifo_wdata !== 8'(8'h30 + id)) begin n_fail++; $display("FAIL rr_wdata c%0d got %h want %h", c, bus.fifo_wdata, 8'(8'h30 + id)); end
                n_chk++; if (bus.fifo_wren !== 1'b1) begin n_fail++; $display("FAIL rr_wren c%0d got %0b want 1", c, bus.fifo_wren); end
            end else begin
                n_chk++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL rr_bubble c%0d got %0b want 0", c, bus.grant_valid); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.req_valid = 4'b1000;
        bus.req_last  = 4'b1000;
        bus.req_data[24 +: 8] = 8'h3C;
        bus.fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            #1;
            n_chk++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd3) begin n_fail++; $display("FAIL bp_hold c%0d got gv%0b id%0d want gv1 id3", c, bus.grant_valid, bus.grant_id); end
            n_chk++; if (bus.fifo_wren !== 1'b0) begin n_fail++; $display("FAIL bp_wren c%0d got %0b want 0", c, bus.fifo_wren); end
            n_chk++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready c%0d got %b want 0000", c, bus.req_ready); end
        end
        bus.fifo_full = 1'b0;
        #1;
        n_chk++; if (bus.fifo_wren !== 1'b1) begin n_fail++; $display("FAIL bp_go_wren got %0b want 1", bus.fifo_wren); end
        n_chk++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_go_ready got %b want 1000", bus.req_ready); end
        n_chk++; if (bus.fifo_wdata !== 8'h3C) begin n_fail++; $display("FAIL bp_go_wdata got %h want 3c", bus.fifo_wdata); end
        step();
        bus.req_valid = '0;
        #1;
        n_chk++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got %0b want 0", bus.grant_valid); end
    endtask

    task automatic test_last_vs_limit();
        do_reset();
        bus.req_valid = 4'b0001;
        bus.req_data[0 +: 8] = 8'h51;
        step();
        #1;
        n_chk++; if (bus.grant_id !== 2'd0 || bus.fifo_wdata !== 8'h51) begin n_fail++; $display("FAIL lim_b1 got id%0d %h want id0 51", bus.grant_id, bus.fifo_wdata); end
        step();
        bus.req_data[0 +: 8] = 8'h52;
        bus.req_last = 4'b0001;
        #1;
        n_chk++; if (bus.fifo_wren !== 1'b1 || bus.fifo_wdata !== 8'h52) begin n_fail++; $display("FAIL lim_b2 got wren%0b %h want wren1 52", bus.fifo_wren, bus.fifo_wdata); end
        step();
        bus.req_valid = 4'b0100;
        bus.req_last  = '0;
        bus.req_data[16 +: 8] = 8'h61;
        #1;
        n_chk++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL lim_last_rel got %0b want 0", bus.grant_valid); end
        step();
        #1;
        n_chk++; if (bus.grant_id !== 2'd2 || bus.fifo_wdata !== 8'h61) begin n_fail++; $display("FAIL lim_p2_b1 got id%0d %h want id2 61", bus.grant_id, bus.fifo_wdata); end
        for (int b = 2; b <= 4; b++) begin
            step();
            bus.req_data[16 +: 8] = 8'(8'h60 + b);
            if (b == 4) bus.req_last = 4'b0100;
            #1;
            n_chk++; if (bus.fifo_wren !== 1'b1 || bus.fifo_wdata !== 8'(8'h60 + b)) begin n_fail++; $display("FAIL lim_p2_b%0d got wren%0b %h want wren1 %h", b, bus.fifo_wren, bus.fifo_wdata, 8'(8'h60 + b)); end
        end
        step();
        bus.req_valid = 4'b1111;
        bus.req_last  = '0;
        #1;
        n_chk++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL lim_one_rel got %0b want 0", bus.grant_valid); end
        step();
        #1;
        n_chk++; if (bus.grant_id !== 2'd3) begin n_fail++; $display("FAIL lim_rr_ptr got %0d want 3", bus.grant_id); end
    endtask

    task automatic test_valid_drop();
        do_reset();
        bus.req_valid = 4'b0110;
        bus.req_data[8 +: 8]  = 8'h71;
        bus.req_data[16 +: 8] = 8'h72;
        step();
        #1;
        n_chk++; if (bus.grant_id !== 2'd1 || bus.fifo_wdata !== 8'h71) begin n_fail++; $display("FAIL drop_b1 got id%0d %h want id1 71", bus.grant_id, bus.fifo_wdata); end
        step();
        bus.req_valid = 4'b0101;
        #1;
        n_chk++; if (bus.fifo_wren !== 1'b0) begin n_fail++; $display("FAIL drop_wren got %0b want 0", bus.fifo_wren); end
        step();
        #1;
        n_chk++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL drop_idle got %0b want 0", bus.grant_valid); end
        step();
        #1;
        n_chk++; if (bus.grant_id !== 2'd2 || bus.fifo_wdata !== 8'h72) begin n_fail++; $display("FAIL drop_next got id%0d %h want id2 72", bus.grant_id, bus.fifo_wdata); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single_producer();
        test_round_robin();
        test_backpressure();
        test_last_vs_limit();
        test_valid_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
